// File: rtl/scoreboard_display_if.sv
// scoreboard_display_if: groups the live score inputs and the multiplexed
// display outputs of the scoreboard display driver.
//   master : the scoreboard side (drives scores, observes the display)
//   slave  : the display driver
interface scoreboard_display_if;
    logic [7:0] score_a;
    logic [7:0] score_b;
    logic [5:0] shot_clock;
    logic [7:0] seg;
    logic [7:0] an;
    logic       conv_busy;

    modport master (
        output score_a, score_b, shot_clock,
        input  seg, an, conv_busy
    );

    modport slave (
        input  score_a, score_b, shot_clock,
        output seg, an, conv_busy
    );
endinterface

// File: rtl/scoreboard_display.sv
// scoreboard_display: drives an 8-digit multiplexed 7-segment display with
// "AA-CC-BB" (Team A score, shot clock, Team B score). Once per display
// frame the three binary values are snapshotted, clamped to 99 and run
// through a sequential double-dabble converter; the six BCD digits are then
// committed to the display registers in one edge so a digit never shows a
// half-updated value.
// Optional: define SHOT_CLOCK_BLINK_EN to blank the shot-clock digits on
// alternate BLINK_DIV periods while the committed shot clock reads 00.
module scoreboard_display #(
    parameter int SCAN_DIV       = 50000,
    parameter bit SEG_ACTIVE_LOW = 1'b1,
    parameter int BLINK_DIV      = 12500000
) (
    input  logic                 clk,
    input  logic                 rst_n,
    scoreboard_display_if.slave  bus
);

    typedef enum logic [1:0] {IDLE, LOAD, SHIFT, COMMIT} state_t;

    localparam int               DIV_W    = $clog2(SCAN_DIV);
    localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(SCAN_DIV - 1);
    localparam logic [3:0]       GL_DASH  = 4'hA;
    localparam logic [3:0]       GL_BLANK = 4'hB;
    localparam logic [7:0]       SEG_OFF  = SEG_ACTIVE_LOW ? 8'hFF : 8'h00;

    logic [DIV_W-1:0] div_cnt;
    logic             tick;
    logic [2:0]       digit_idx;
    logic [2:0]       idx_next;
    logic [3:0]       glyph_sel;
    logic             start_pending;
    state_t           state, state_next;
    logic             pend_clr, load_en, shift_en, commit_en;
    logic [7:0]       snap_c, snap_b;
    logic [15:0]      dd_sr, dd_next;
    logic [2:0]       bit_cnt;
    logic [1:0]       val_sel;
    logic [3:0]       tmp_at, tmp_ao, tmp_ct, tmp_co, tmp_bt, tmp_bo;
    logic [3:0]       disp_at, disp_ao, disp_ct, disp_co, disp_bt, disp_bo;
    logic             blink_phase;
    logic             blank_clk;
    logic [7:0]       seg_q, an_q;

    function automatic logic [7:0] clamp99(input logic [7:0] v);
        return (v > 8'd99) ? 8'd99 : v;
    endfunction

    // One double-dabble step: correct each BCD nibble, then shift left.
    function automatic logic [15:0] dd_step(input logic [15:0] v);
        logic [15:0] t;
        t = v;
        if (t[11:8] >= 4'd5)  t[11:8]  = t[11:8]  + 4'd3;
        if (t[15:12] >= 4'd5) t[15:12] = t[15:12] + 4'd3;
        return {t[14:0], 1'b0};
    endfunction

    // Glyph code 0-9 = digit, A = dash, anything else = blank; {g..a}.
    function automatic logic [6:0] seg_code(input logic [3:0] g);
        case (g)
            4'd0:    return 7'h3F;
            4'd1:    return 7'h06;
            4'd2:    return 7'h5B;
            4'd3:    return 7'h4F;
            4'd4:    return 7'h66;
            4'd5:    return 7'h6D;
            4'd6:    return 7'h7D;
            4'd7:    return 7'h07;
            4'd8:    return 7'h7F;
            4'd9:    return 7'h6F;
            4'hA:    return 7'h40;
            default: return 7'h00;
        endcase
    endfunction

    // Decimal point is never lit; polarity applied last.
    function automatic logic [7:0] seg_drive(input logic [6:0] code);
        return SEG_ACTIVE_LOW ? ~{1'b0, code} : {1'b0, code};
    endfunction

    assign tick     = (div_cnt == DIV_LAST);
    assign idx_next = digit_idx + 3'd1;
    assign dd_next  = dd_step(dd_sr);

    // Digit-slot divider: terminal count is the scan tick.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)    div_cnt <= '0;
        else if (tick) div_cnt <= '0;
        else           div_cnt <= div_cnt + DIV_W'(1);
    end

`ifdef SHOT_CLOCK_BLINK_EN
    localparam int               BLK_W    = $clog2(BLINK_DIV);
    localparam logic [BLK_W-1:0] BLK_LAST = BLK_W'(BLINK_DIV - 1);
    logic [BLK_W-1:0] blink_cnt;

    // Free-running blink timebase; phase flips every BLINK_DIV cycles.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            blink_cnt   <= '0;
            blink_phase <= 1'b0;
        end else if (blink_cnt == BLK_LAST) begin
            blink_cnt   <= '0;
            blink_phase <= ~blink_phase;
        end else begin
            blink_cnt   <= blink_cnt + BLK_W'(1);
        end
    end
`else
    // No blink timebase: phase is constant low for any legal BLINK_DIV.
    assign blink_phase = (BLINK_DIV < 0);
`endif

    assign blank_clk = blink_phase && (disp_ct == 4'd0) && (disp_co == 4'd0);

    // Glyph for the digit slot that becomes active on the next tick.
    always_comb begin
        glyph_sel = GL_BLANK;
        case (idx_next)
            3'd7:    glyph_sel = disp_at;
            3'd6:    glyph_sel = disp_ao;
            3'd5:    glyph_sel = GL_DASH;
            3'd4:    glyph_sel = blank_clk ? GL_BLANK : disp_ct;
            3'd3:    glyph_sel = blank_clk ? GL_BLANK : disp_co;
            3'd2:    glyph_sel = GL_DASH;
            3'd1:    glyph_sel = disp_bt;
            default: glyph_sel = disp_bo;
        endcase
    end

    // Registered scan outputs, advanced only on tick.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            digit_idx <= 3'd0;
            an_q      <= 8'hFF;
            seg_q     <= SEG_OFF;
        end else if (tick) begin
            digit_idx <= idx_next;
            an_q      <= ~(8'd1 << idx_next);
            seg_q     <= seg_drive(seg_code(glyph_sel));
        end
    end

    // Frame request: set on 7->0 wrap; a wrap coinciding with service wins.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) start_pending <= 1'b1;
        else        start_pending <= (start_pending & ~pend_clr) | (tick & (digit_idx == 3'd7));
    end

    // Conversion FSM state register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= IDLE;
        else        state <= state_next;
    end

    // Conversion FSM next state and strobes.
    always_comb begin
        state_next = state;
        pend_clr   = 1'b0;
        load_en    = 1'b0;
        shift_en   = 1'b0;
        commit_en  = 1'b0;
        case (state)
            IDLE: if (start_pending) begin
                pend_clr   = 1'b1;
                state_next = LOAD;
            end
            LOAD: begin
                load_en    = 1'b1;
                state_next = SHIFT;
            end
            SHIFT: begin
                shift_en = 1'b1;
                if (bit_cnt == 3'd7 && val_sel == 2'd2) state_next = COMMIT;
            end
            COMMIT: begin
                commit_en  = 1'b1;
                state_next = IDLE;
            end
            default: state_next = IDLE;
        endcase
    end

    // Snapshot and double-dabble datapath; A goes straight into the shifter,
    // clock and B wait in the snapshot until their turn (order A, clock, B).
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            snap_c  <= 8'd0;
            snap_b  <= 8'd0;
            dd_sr   <= 16'd0;
            bit_cnt <= 3'd0;
            val_sel <= 2'd0;
            tmp_at  <= 4'd0;
            tmp_ao  <= 4'd0;
            tmp_ct  <= 4'd0;
            tmp_co  <= 4'd0;
            tmp_bt  <= 4'd0;
            tmp_bo  <= 4'd0;
        end else if (load_en) begin
            snap_c  <= clamp99({2'b00, bus.shot_clock});
            snap_b  <= clamp99(bus.score_b);
            dd_sr   <= {8'h00, clamp99(bus.score_a)};
            bit_cnt <= 3'd0;
            val_sel <= 2'd0;
        end else if (shift_en) begin
            bit_cnt <= bit_cnt + 3'd1;
            if (bit_cnt == 3'd7) begin
                case (val_sel)
                    2'd0:    {tmp_at, tmp_ao} <= dd_next[15:8];
                    2'd1:    {tmp_ct, tmp_co} <= dd_next[15:8];
                    default: {tmp_bt, tmp_bo} <= dd_next[15:8];
                endcase
                val_sel <= val_sel + 2'd1;
                dd_sr   <= {8'h00, (val_sel == 2'd0) ? snap_c : snap_b};
            end else begin
                dd_sr   <= dd_next;
            end
        end
    end

    // Atomic commit of all six digits to the display registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            disp_at <= 4'd0;
            disp_ao <= 4'd0;
            disp_ct <= 4'd0;
            disp_co <= 4'd0;
            disp_bt <= 4'd0;
            disp_bo <= 4'd0;
        end else if (commit_en) begin
            disp_at <= tmp_at;
            disp_ao <= tmp_ao;
            disp_ct <= tmp_ct;
            disp_co <= tmp_co;
            disp_bt <= tmp_bt;
            disp_bo <= tmp_bo;
        end
    end

    assign bus.seg       = seg_q;
    assign bus.an        = an_q;
    assign bus.conv_busy = (state != IDLE);

endmodule
